// File: rtl/hero_mov_ctrl.sv
// Hero movement controller: maps keypad presses to fly/jump/crouch actions with hold, cooldown and a one-deep press buffer.
// Optional HOLD_EXTEND_EN: a held fly key keeps reloading the hold counter so fly is sustained while held.
module hero_mov_ctrl #(
    parameter int KEY_W      = 5,
    parameter int STATE_W    = 4,
    parameter int GAME_STATE = 3,
    parameter int KEY_FLY    = 2,
    parameter int KEY_JUMP   = 6,
    parameter int KEY_DUCK   = 8,
    parameter int CNT_W      = 8,
    parameter int HOLD_TICKS = 16,
    parameter int COOL_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               keypad_pressed,
    input  logic [KEY_W-1:0]   key,
    input  logic [STATE_W-1:0] presente,
    input  logic               tick,
    output logic [1:0]         mov,
    output logic               busy,
    output logic               pending,
    output logic               act_start
);

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] COOL_CNT = CNT_W'(COOL_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       mov_reg, mov_next;
    logic [1:0]       pend_code_reg, pend_code_next;
    logic             pend_reg, pend_next;
    logic             start_reg, start_next;
    logic             kp_prev_reg;

    logic [1:0] key_code;
    logic       press_evt;
    logic       gated;
    logic       cnt_last;
    logic       extend;
    logic [1:0] buf_code;

    always_comb begin
        key_code = 2'd0;
        if (key == KEY_W'(KEY_FLY))
            key_code = 2'd1;
        else if (key == KEY_W'(KEY_JUMP))
            key_code = 2'd2;
        else if (key == KEY_W'(KEY_DUCK))
            key_code = 2'd3;
    end

    assign press_evt = keypad_pressed & ~kp_prev_reg & (key_code != 2'd0);
    assign gated     = (presente != STATE_W'(GAME_STATE));
    assign cnt_last  = (cnt_reg == CNT_ONE);
    // A press on the expiry edge is newer than anything already buffered.
    assign buf_code  = press_evt ? key_code : pend_code_reg;

`ifdef HOLD_EXTEND_EN
    assign extend = (mov_reg == 2'd1) & keypad_pressed & (key == KEY_W'(KEY_FLY));
`else
    assign extend = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mov_next       = mov_reg;
        pend_next      = pend_reg;
        pend_code_next = pend_code_reg;
        start_next     = 1'b0;

        if (gated) begin
            state_next = IDLE;
            cnt_next   = '0;
            mov_next   = 2'd0;
            pend_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (press_evt) begin
                        state_next = ACTIVE;
                        cnt_next   = HOLD_CNT;
                        mov_next   = key_code;
                        start_next = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (press_evt) begin
                        pend_next      = 1'b1;
                        pend_code_next = key_code;
                    end
                    if (tick) begin
                        if (extend) begin
                            cnt_next = HOLD_CNT;
                        end else if (cnt_last) begin
                            mov_next = 2'd0;
                            if (COOL_TICKS > 0) begin
                                state_next = COOLDOWN;
                                cnt_next   = COOL_CNT;
                            end else if (press_evt || pend_reg) begin
                                cnt_next   = HOLD_CNT;
                                mov_next   = buf_code;
                                start_next = 1'b1;
                                pend_next  = 1'b0;
                            end else begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end
                        end else if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                end
                COOLDOWN: begin
                    if (press_evt) begin
                        pend_next      = 1'b1;
                        pend_code_next = key_code;
                    end
                    if (tick) begin
                        if (cnt_last) begin
                            if (press_evt || pend_reg) begin
                                state_next = ACTIVE;
                                cnt_next   = HOLD_CNT;
                                mov_next   = buf_code;
                                start_next = 1'b1;
                                pend_next  = 1'b0;
                            end else begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end
                        end else if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    mov_next   = 2'd0;
                    pend_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mov_reg       <= 2'd0;
            pend_reg      <= 1'b0;
            pend_code_reg <= 2'd0;
            start_reg     <= 1'b0;
            kp_prev_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mov_reg       <= mov_next;
            pend_reg      <= pend_next;
            pend_code_reg <= pend_code_next;
            start_reg     <= start_next;
            kp_prev_reg   <= keypad_pressed;
        end
    end

    assign mov       = mov_reg;
    assign busy      = (state_reg != IDLE);
    assign pending   = pend_reg;
    assign act_start = start_reg;

endmodule

// File: tb/tb_hero_mov_ctrl.sv
// Scoreboard bench for hero_mov_ctrl: a tick/hold/cooldown reference model feeds expected outputs to a negedge monitor.
module tb_hero_mov_ctrl;

    localparam int HOLD = 4;
    localparam int COOL = 2;
`ifdef HOLD_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       keypad_pressed = 1'b0;
    logic [4:0] key = 5'd0;
    logic [3:0] presente = 4'd3;
    logic       tick = 1'b0;
    logic [1:0] mov;
    logic       busy, pending, act_start;

    always #5 clk = ~clk;

    hero_mov_ctrl #(.HOLD_TICKS(HOLD), .COOL_TICKS(COOL)) dut (
        .clk(clk), .rst_n(rst_n), .keypad_pressed(keypad_pressed), .key(key),
        .presente(presente), .tick(tick), .mov(mov), .busy(busy),
        .pending(pending), .act_start(act_start)
    );

    typedef struct packed {
        logic [1:0] mov;
        logic       busy;
        logic       pending;
        logic       act_start;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int act_seen = 0;
    int mov_cycles = 0;
    int busy_cycles = 0;

    // Reference model: action code plus remaining hold ticks, remaining cooldown ticks and buffered code (0 = empty).
    int m_act = 0, m_hold = 0, m_cool = 0, m_buf = 0;
    bit m_prev = 0, m_start = 0;

    function automatic int code_of(input logic [4:0] k);
        if (k == 5'd2) return 1;
        if (k == 5'd6) return 2;
        if (k == 5'd8) return 3;
        return 0;
    endfunction

    function automatic void launch(input int c);
        m_act   = c;
        m_hold  = HOLD;
        m_start = 1'b1;
    endfunction

    function automatic void model_reset();
        m_act = 0; m_hold = 0; m_cool = 0; m_buf = 0; m_prev = 0; m_start = 0;
    endfunction

    function automatic void model_update(input bit kp, input logic [4:0] k, input logic [3:0] p, input bit t);
        int c;
        bit ev;
        c = code_of(k);
        ev = kp && !m_prev && (c != 0);
        m_prev = kp;
        m_start = 1'b0;
        if (p != 4'd3) begin
            m_act = 0; m_hold = 0; m_cool = 0; m_buf = 0;
        end else if (m_hold == 0 && m_cool == 0) begin
            if (ev) launch(c);
        end else begin
            if (ev) m_buf = c;
            if (t) begin
                if (m_hold > 0) begin
                    if (EXT && m_act == 1 && kp && k == 5'd2) begin
                        m_hold = HOLD;
                    end else begin
                        m_hold = m_hold - 1;
                        if (m_hold == 0) begin
                            m_act = 0;
                            m_cool = COOL;
                            if (m_cool == 0 && m_buf != 0) begin
                                launch(m_buf);
                                m_buf = 0;
                            end
                        end
                    end
                end else begin
                    m_cool = m_cool - 1;
                    if (m_cool == 0 && m_buf != 0) begin
                        launch(m_buf);
                        m_buf = 0;
                    end
                end
            end
        end
    endfunction

    task automatic step(input bit kp, input logic [4:0] k, input logic [3:0] p, input bit t);
        exp_t e;
        keypad_pressed = kp;
        key = k;
        presente = p;
        tick = t;
        @(posedge clk);
        model_update(kp, k, p, t);
        e.mov       = (m_hold > 0) ? 2'(m_act) : 2'd0;
        e.busy      = (m_hold > 0) || (m_cool > 0);
        e.pending   = (m_buf != 0);
        e.act_start = m_start;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("mov", int'(mov), int'(e.mov));
            check_val("busy", int'(busy), int'(e.busy));
            check_val("pending", int'(pending), int'(e.pending));
            check_val("act_start", int'(act_start), int'(e.act_start));
            if (mov != 2'd0) mov_cycles++;
            if (busy) busy_cycles++;
            if (act_start) begin
                act_seen++;
                $display("action start mov=%0d pending=%0d t=%0t", mov, pending, $time);
            end
        end
    end

    task automatic clear_counts();
        act_seen = 0;
        mov_cycles = 0;
        busy_cycles = 0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        keypad_pressed = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val({name, "_mov"}, int'(mov), 0);
        check_val({name, "_busy"}, int'(busy), 0);
        check_val({name, "_pending"}, int'(pending), 0);
        check_val({name, "_act_start"}, int'(act_start), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit         kp_r;
        logic [4:0] key_r;
        int         gate_left;

        async_reset("reset");
        repeat (3) step(0, 5'd0, 4'd3, 1);

        // Jump: 4 ticks active, 2 ticks cooldown.
        clear_counts();
        step(1, 5'd6, 4'd3, 1);
        step(1, 5'd6, 4'd3, 1);
        step(0, 5'd0, 4'd3, 1);
        repeat (10) step(0, 5'd0, 4'd3, 1);
        check_val("t1_mov_cycles", mov_cycles, HOLD);
        check_val("t1_busy_cycles", busy_cycles, HOLD + COOL);
        check_val("t1_actions", act_seen, 1);

        // Unmapped key, then a long fly hold.
        clear_counts();
        repeat (3) step(1, 5'd5, 4'd3, 1);
        repeat (2) step(0, 5'd5, 4'd3, 1);
        repeat (20) step(1, 5'd2, 4'd3, 1);
        repeat (12) step(0, 5'd0, 4'd3, 1);
        check_val("t2_actions", act_seen, 1);
        check_val("t2_mov_cycles", mov_cycles, EXT ? 23 : HOLD);

        // Buffered presses: latest wins and starts straight after cooldown.
        clear_counts();
        step(1, 5'd2, 4'd3, 1);
        step(0, 5'd2, 4'd3, 1);
        step(1, 5'd6, 4'd3, 1);
        step(0, 5'd6, 4'd3, 1);
        step(1, 5'd8, 4'd3, 1);
        step(0, 5'd8, 4'd3, 1);
        repeat (14) step(0, 5'd0, 4'd3, 1);
        check_val("t3_actions", act_seen, 2);
        check_val("t3_mov_cycles", mov_cycles, 2 * HOLD);

        // Leaving the game state aborts and blocks presses.
        clear_counts();
        step(1, 5'd6, 4'd3, 1);
        step(0, 5'd6, 4'd3, 1);
        step(0, 5'd0, 4'd2, 1);
        step(1, 5'd8, 4'd2, 1);
        step(0, 5'd8, 4'd2, 1);
        repeat (5) step(0, 5'd0, 4'd3, 1);
        check_val("t4_actions", act_seen, 1);
        check_val("t4_mov_cycles", mov_cycles, 2);

        // Sparse timebase, then an asynchronous reset mid-action.
        step(1, 5'd8, 4'd3, 0);
        for (int i = 0; i < 20; i++) step(0, 5'd8, 4'd3, (i % 3) == 2);
        step(1, 5'd6, 4'd3, 0);
        for (int i = 0; i < 5; i++) step(0, 5'd0, 4'd3, (i % 3) == 2);
        async_reset("t5_reset");
        repeat (4) step(0, 5'd0, 4'd3, 1);

        // Randomised traffic.
        kp_r = 1'b0;
        key_r = 5'd0;
        gate_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] p;
            if ($urandom_range(0, 4) == 0) begin
                kp_r = !kp_r;
                if (kp_r) begin
                    case ($urandom_range(0, 4))
                        0: key_r = 5'd2;
                        1: key_r = 5'd6;
                        2: key_r = 5'd8;
                        3: key_r = 5'd5;
                        default: key_r = 5'($urandom);
                    endcase
                end
            end
            if (gate_left == 0 && $urandom_range(0, 59) == 0) gate_left = $urandom_range(1, 4);
            p = 4'd3;
            if (gate_left > 0) begin
                p = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd9;
                gate_left--;
            end
            step(kp_r, key_r, p, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 599) == 0) begin
                async_reset("rand_reset");
                kp_r = 1'b0;
            end
        end

        step(0, 5'd0, 4'd3, 1);
        @(negedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hero_mov_ctrl.md
Name: hero_mov_ctrl

Overview:
Parametrised hero movement controller for the game's play state. Maps keypad codes to fly/jump/crouch actions. Each action is held for a programmable number of timebase ticks, then followed by a cooldown. One press that arrives during an action or its cooldown is buffered and replayed afterwards. Sits between the keypad decoder and the hero sprite/collision logic.

Parameters:
KEY_W, 5, keypad code width
STATE_W, 4, game state bus width
GAME_STATE, 3, state code in which movement is enabled
KEY_FLY, 2, key code for fly (mov=1)
KEY_JUMP, 6, key code for jump (mov=2)
KEY_DUCK, 8, key code for crouch (mov=3)
CNT_W, 8, duration counter width
HOLD_TICKS, 16, ticks an action stays active (1..2^CNT_W-1)
COOL_TICKS, 4, ticks of cooldown after an action (0 = no cooldown)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
keypad_pressed  in  1  level, high while a key is down
key  in  KEY_W  current key code
presente  in  STATE_W  current game state
tick  in  1  timebase enable, one-cycle pulse
mov  out  2  0 idle, 1 fly, 2 jump, 3 crouch
busy  out  1  high in ACTIVE or COOLDOWN
pending  out  1  buffered action waiting
act_start  out  1  one-cycle pulse when an action begins

Behaviour:
- Reset (async, rst_n=0): mov=0, busy=0, pending=0, act_start=0, FSM=IDLE, counter=0, press-edge register=0.
- Press event: rising edge of keypad_pressed (registered previous value), with key equal to KEY_FLY, KEY_JUMP or KEY_DUCK. Other codes are ignored. A key that stays held never retriggers.
- Gate: when presente != GAME_STATE, the block aborts on the next edge: mov=0, pending cleared, FSM=IDLE. Press events are ignored while gated.
- IDLE: on a press event at edge T, the following take effect after T:
  - mov = code
  - counter = HOLD_TICKS
  - FSM = ACTIVE
  - act_start = 1 for one cycle
  - Latency: 1 cycle.
- ACTIVE: counter decrements on each tick. When tick=1 and counter==1:
  - mov=0
  - If COOL_TICKS>0: counter=COOL_TICKS, FSM=COOLDOWN.
  - Else: start the pending action, or go to IDLE.
  - mov is therefore nonzero for exactly HOLD_TICKS ticks.
- COOLDOWN: mov=0. Counter decrements on tick. When tick=1 and counter==1:
  - If pending: start the buffered action the same way as from IDLE, act_start=1, pending cleared.
  - Else: FSM=IDLE.
- Buffer: a press event in ACTIVE or COOLDOWN stores its code and sets pending=1. A later event overwrites it (latest wins).
- Simultaneous events:
  - Press event on the same edge as action/cooldown expiry: the new event overwrites the buffer, and the buffered action (the new one) starts.
  - Gate abort has priority over everything.
- tick=0: all counters are frozen; FSM holds.
- busy = (FSM != IDLE).
- Counters never underflow.

Optional Feature:
HOLD_EXTEND_EN
- Defined: in ACTIVE with mov=1 (fly), if keypad_pressed=1 and key==KEY_FLY on a tick, counter reloads to HOLD_TICKS. Fly is sustained while the key is held; expiry begins HOLD_TICKS ticks after release.
- Undefined: fly is a fixed HOLD_TICKS pulse like the other actions.

Test Plan:
1. HOLD_TICKS=4, COOL_TICKS=2, tick=1, presente=3; press key 6 -> act_start pulse at cycle+1; mov=2 for exactly 4 cycles; busy high 6 cycles; then IDLE.
2. Press key 5 (unmapped), then hold key 2 for 20 cycles -> key 5 has no effect; key 2 gives one fly action only (mov=1 for 4 cycles, no retrigger).
3. Press key 2, then during ACTIVE press 6, then 8 -> pending=1; key 8 overwrites key 6; after cooldown mov=3 starts with no IDLE cycle; pending cleared.
4. During ACTIVE set presente=2 -> mov=0, busy=0, pending=0 next cycle; presses ignored until presente=3.
5. tick asserted every 3rd cycle, press 8 -> mov=3 for 12 cycles; rst_n pulsed low mid-action -> mov=0 immediately (asynchronous).
6. HOLD_EXTEND_EN defined: hold key 2 for 10 cycles -> mov=1 until 4 ticks after release. Undefined: mov=1 for 4 cycles only.
